// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the fetch sequencer and its RAS.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } sel_t;

    localparam int unsigned RAS_DEPTH_DEF = 4;
    localparam int unsigned RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

    // Pointer width for an arbitrary stack depth; never narrower than 1 bit.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ras.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ras
// Brief    : Circular return-address stack with saturating occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ras
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full
);

    localparam int unsigned C_PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam logic [C_PTR_W:0] C_FULL = (C_PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
    logic [C_PTR_W-1:0] r_wp;
    logic [C_PTR_W:0]   r_count;
    logic [C_PTR_W-1:0] w_top_idx;
    logic               w_do_pop;
    logic               w_do_push;

    // r_wp names the next free slot; when full it names the oldest entry,
    // so a push in that state overwrites it.
    assign w_top_idx = r_wp - C_PTR_W'(1);
    assign empty     = (r_count == '0);
    assign full      = (r_count == C_FULL);
    assign top_data  = r_mem[w_top_idx];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && !w_do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_count <= '0;
        end else if (w_do_pop) begin
            r_wp    <= w_top_idx;
            r_count <= r_count - 1'b1;
        end else if (w_do_push) begin
            r_wp <= r_wp + C_PTR_W'(1);
            if (!full) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Next-PC sequencer: jump, call/return, relative branch, stall, halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned JADDR_W   = 13,
    parameter int unsigned IMM_W     = 7,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0,
    parameter bit          HALT_EN   = 1'b1,
    parameter int unsigned HALT_PC   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump,
    input  logic               call,
    input  logic               ret,
    input  logic               branch,
    input  logic               branch_cond,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic [IMM_W-1:0]   branch_off,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic               halted,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] C_HALT_PC  = ADDR_W'(HALT_PC);

    state_t            r_state;
    state_t            w_state_nxt;
    sel_t              w_sel;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_sel_pc;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_jmp_target;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_active;
    logic              w_push;
    logic              w_pop;
    logic              r_ovf;
    logic              r_udf;

    assign w_pc_plus1  = r_pc + ADDR_W'(1);
    assign w_br_off    = ADDR_W'($signed(branch_off));
    assign w_br_target = w_pc_plus1 + w_br_off;

    generate
        if (JADDR_W == ADDR_W) begin : g_jaddr_full
            assign w_jmp_target = ADDR_W'(jump_addr);
        end else begin : g_jaddr_page
            assign w_jmp_target = {w_pc_plus1[ADDR_W-1:JADDR_W], jump_addr};
        end
    endgenerate

    assign w_active = (r_state == RUN) && !stall;
    assign w_push   = w_active && (w_sel == SEL_CALL);
    assign w_pop    = w_active && (w_sel == SEL_RET);

    fetch_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus1),
        .top_data  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    always_comb begin
        w_sel = SEL_SEQ;
        if (ret)                       w_sel = SEL_RET;
        else if (call)                 w_sel = SEL_CALL;
        else if (jump)                 w_sel = SEL_JMP;
        else if (branch && branch_cond) w_sel = SEL_BR;
    end

    // A return on an empty stack falls through to the sequential address.
    always_comb begin
        w_sel_pc = w_pc_plus1;
        case (w_sel)
            SEL_RET:  w_sel_pc = w_ras_empty ? w_pc_plus1 : w_ras_top;
            SEL_CALL: w_sel_pc = w_jmp_target;
            SEL_JMP:  w_sel_pc = w_jmp_target;
            SEL_BR:   w_sel_pc = w_br_target;
            default:  w_sel_pc = w_pc_plus1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_active) begin
            w_pc_nxt = w_sel_pc;
            if (HALT_EN && (w_sel_pc == C_HALT_PC)) begin
                w_state_nxt = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= C_RESET_PC;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_push && w_ras_full)  r_ovf <= 1'b1;
            if (w_pop && w_ras_empty)  r_udf <= 1'b1;
        end
    end

    assign pc            = r_pc;
    assign pc_valid      = (r_state == RUN);
    assign halted        = (r_state == HALT);
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed checks of fetch_unit with halt enabled and disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        branch = 1'b0;
    logic        branch_cond = 1'b0;
    logic [12:0] jump_addr = '0;
    logic [6:0]  branch_off = '0;

    logic [15:0] pc_h,  pc_n;
    logic        vld_h, vld_n;
    logic        hlt_h, hlt_n;
    logic        ovf_h, ovf_n;
    logic        udf_h, udf_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W(16), .JADDR_W(13), .IMM_W(7), .RAS_DEPTH(4),
        .RESET_PC(0), .HALT_EN(1'b1), .HALT_PC(10)
    ) dut_h (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .call(call),
        .ret(ret), .branch(branch), .branch_cond(branch_cond),
        .jump_addr(jump_addr), .branch_off(branch_off),
        .pc(pc_h), .pc_valid(vld_h), .halted(hlt_h),
        .ras_overflow(ovf_h), .ras_underflow(udf_h)
    );

    fetch_unit #(
        .ADDR_W(16), .JADDR_W(13), .IMM_W(7), .RAS_DEPTH(4),
        .RESET_PC(0), .HALT_EN(1'b0), .HALT_PC(10)
    ) dut_n (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .call(call),
        .ret(ret), .branch(branch), .branch_cond(branch_cond),
        .jump_addr(jump_addr), .branch_off(branch_off),
        .pc(pc_n), .pc_valid(vld_n), .halted(hlt_n),
        .ras_overflow(ovf_n), .ras_underflow(udf_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump = 0; call = 0; ret = 0; branch = 0; branch_cond = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_jump(input logic [12:0] a);
        idle(); jump = 1; jump_addr = a; tick(); idle();
    endtask

    task automatic do_call(input logic [12:0] a);
        idle(); call = 1; jump_addr = a; tick(); idle();
    endtask

    task automatic do_ret();
        idle(); ret = 1; tick(); idle();
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        // Sequential fetch into the halt address
        do_reset();
        chk("rst_pc", pc_h, 16'h0000);
        chk("rst_valid", 16'(vld_h), 16'h1);
        chk("rst_halted", 16'(hlt_h), 16'h0);
        chk("rst_ovf", 16'(ovf_h), 16'h0);
        chk("rst_udf", 16'(udf_h), 16'h0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("seq_pc", pc_h, 16'(i));
            if (i == 9) chk("seq9_valid", 16'(vld_h), 16'h1);
        end
        chk("halt_halted", 16'(hlt_h), 16'h1);
        chk("halt_valid", 16'(vld_h), 16'h0);
        jump = 1; jump_addr = 13'h0055;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_hold_pc", pc_h, 16'h000A);
            chk("halt_hold_flag", 16'(hlt_h), 16'h1);
        end
        idle();

        // Reset leaves HALT; jump keeps upper bits of pc+1
        do_reset();
        chk("unhalt_pc", pc_h, 16'h0000);
        chk("unhalt_halted", 16'(hlt_h), 16'h0);
        do_jump(13'h1FFF);
        chk("jmp_1fff", pc_n, 16'h1FFF);
        tick();
        chk("inc_2000", pc_n, 16'h2000);
        do_jump(13'h0FFE);
        chk("jmp_2ffe", pc_n, 16'h2FFE);
        do_jump(13'h0123);
        chk("jmp_upper", pc_n, 16'h2123);

        // Climb to 0xFFFF and wrap
        for (int k = 0; k < 6; k++) begin
            do_jump(13'h1FFF);
            tick();
        end
        chk("climb_e000", pc_n, 16'hE000);
        do_jump(13'h1FFF);
        chk("top_ffff", pc_n, 16'hFFFF);
        tick();
        chk("wrap_0000", pc_n, 16'h0000);

        // Relative branch, taken and not taken, and jump over branch
        do_jump(13'h0040);
        chk("br_start", pc_n, 16'h0040);
        branch = 1; branch_cond = 1; branch_off = 7'h7C; tick(); idle();
        chk("br_taken", pc_n, 16'h003D);
        do_jump(13'h0040);
        branch = 1; branch_cond = 0; branch_off = 7'h7C; tick(); idle();
        chk("br_not_taken", pc_n, 16'h0041);
        jump = 1; jump_addr = 13'h0100; branch = 1; branch_cond = 1; tick(); idle();
        chk("jmp_over_br", pc_n, 16'h0100);

        // RAS overflow and underflow
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            do_jump(13'(k * 16));
            do_call(13'h0200);
            chk("call_pc", pc_n, 16'h0200);
            if (k == 4) chk("ovf_before", 16'(ovf_n), 16'h0);
        end
        chk("ovf_set", 16'(ovf_n), 16'h1);
        do_ret(); chk("ret1", pc_n, 16'h0051);
        do_ret(); chk("ret2", pc_n, 16'h0041);
        do_ret(); chk("ret3", pc_n, 16'h0031);
        do_ret(); chk("ret4", pc_n, 16'h0021);
        chk("udf_before", 16'(udf_n), 16'h0);
        do_ret(); chk("ret5_pc", pc_n, 16'h0022);
        chk("udf_set", 16'(udf_n), 16'h1);

        // Stall discards requests; call+ret pops only
        do_reset();
        do_jump(13'h0010);
        do_call(13'h0300);
        do_call(13'h0400);
        chk("pre_stall", pc_n, 16'h0400);
        stall = 1; jump = 1; jump_addr = 13'h0077;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_n, 16'h0400);
            chk("stall_flags", {14'h0, ovf_n, udf_n}, 16'h0);
        end
        idle();
        call = 1; ret = 1; jump_addr = 13'h0500; tick(); idle();
        chk("callret_pop", pc_n, 16'h0301);
        do_ret(); chk("callret_next", pc_n, 16'h0011);
        chk("callret_udf0", 16'(udf_n), 16'h0);
        do_ret(); chk("callret_empty", pc_n, 16'h0012);
        chk("callret_udf1", 16'(udf_n), 16'h1);
        chk("callret_ovf0", 16'(ovf_n), 16'h0);

        // Reset during a stall with three entries and a sticky flag
        do_reset();
        do_ret();
        chk("mid_udf_pre", 16'(udf_n), 16'h1);
        do_call(13'h0010);
        do_call(13'h0010);
        do_call(13'h0010);
        chk("mid_pc_pre", pc_n, 16'h0010);
        stall = 1; rst = 1; tick(); rst = 0; idle();
        chk("mid_rst_pc", pc_n, 16'h0000);
        chk("mid_rst_flags", {14'h0, ovf_n, udf_n}, 16'h0);
        chk("mid_rst_valid", 16'(vld_n), 16'h1);
        do_ret();
        chk("mid_rst_empty_pc", pc_n, 16'h0001);
        chk("mid_rst_empty_udf", 16'(udf_n), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
